// File: rtl/ram_byte_access_ctrl.sv
// Byte-serialising request sequencer in front of a single-port-style byte RAM.
// Splits 8/16-bit little-endian requests into one or two RAM byte cycles.
module ram_byte_access_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_WR,
  input  logic            REQ_WIDE,
  input  logic [AW-1:0]   REQ_ADDR,
  input  logic [2*DW-1:0] REQ_WDATA,
  output logic            RSP_VALID,
  output logic [2*DW-1:0] RSP_RDATA,
  output logic            RAM_WE,
  output logic            RAM_RE,
  output logic [AW-1:0]   RAM_RA,
  output logic [AW-1:0]   RAM_WA,
  output logic [DW-1:0]   RAM_WD,
  input  logic [DW-1:0]   RAM_Q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYTE0,
    S_BYTE1,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     addr_inc;
  logic [AW-1:0]     ram_addr;
  logic [2*DW-1:0]   wdata_q;
  logic [2*DW-1:0]   rdata_q;
  logic              wr_q;
  logic              wide_q;
  logic              accept;

  assign accept   = REQ_VALID && (state_q == S_IDLE);
  // Natural AW-bit overflow gives the required wrap from the top byte to 0.
  assign addr_inc = addr_q + {{(AW-1){1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      wide_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        wr_q    <= REQ_WR;
        wide_q  <= REQ_WIDE;
        rdata_q <= '0;
      end
      // RAM_Q is only meaningful while RAM_RE is high, i.e. in a read byte state.
      if (state_q == S_BYTE0 && !wr_q) rdata_q[DW-1:0]    <= RAM_Q;
      if (state_q == S_BYTE1 && !wr_q) rdata_q[2*DW-1:DW] <= RAM_Q;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RAM_WE    = 1'b0;
    RAM_RE    = 1'b0;
    ram_addr  = addr_q;
    RAM_WD    = wdata_q[DW-1:0];
    case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_d = S_BYTE0;
      end
      S_BYTE0: begin
        RAM_WE  = wr_q;
        RAM_RE  = !wr_q;
        state_d = wide_q ? S_BYTE1 : S_RESP;
      end
      S_BYTE1: begin
        ram_addr = addr_inc;
        RAM_WD   = wdata_q[2*DW-1:DW];
        RAM_WE   = wr_q;
        RAM_RE   = !wr_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RAM_RA    = ram_addr;
  assign RAM_WA    = ram_addr;
  assign RSP_RDATA = rdata_q;

endmodule

// File: tb/tb_ram_byte_access_ctrl.sv
// Directed bench for ram_byte_access_ctrl with a behavioural 1024x8 RAM and
// a response scoreboard filled at accept time and drained on RSP_VALID.
module tb_ram_byte_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID, REQ_READY, REQ_WR, REQ_WIDE;
  logic [9:0]  REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        RAM_WE, RAM_RE;
  logic [9:0]  RAM_RA, RAM_WA;
  logic [7:0]  RAM_WD;
  logic [7:0]  RAM_Q;

  logic [7:0]  mem [1024] = '{default: 8'h00};
  logic [15:0] sb [$];
  int          compared = 0;
  int          mismatched = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RAM_WE) mem[RAM_WA] <= RAM_WD;
  assign RAM_Q = RAM_RE ? mem[RAM_RA] : 8'hzz;

  ram_byte_access_ctrl #(.AW(10), .DW(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_WIDE(REQ_WIDE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .RAM_RA(RAM_RA), .RAM_WA(RAM_WA),
    .RAM_WD(RAM_WD), .RAM_Q(RAM_Q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard head and compares it with the live response data.
  task automatic check_rsp(input string tag);
    logic [15:0] exp;
    if (sb.size() == 0) begin
      check({tag, " sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check({tag, " rdata"}, 32'(RSP_RDATA), 32'(exp));
    end
  endtask

  task automatic do_req(input logic wr, input logic wide, input logic [9:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input int exp_lat, input string tag);
    int waited;
    int lat;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WR = wr; REQ_WIDE = wide; REQ_ADDR = addr; REQ_WDATA = wdata;
    waited = 0;
    while (!REQ_READY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!REQ_READY) begin
      check({tag, " accept_timeout"}, 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    sb.push_back(exp_rd);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (RSP_VALID) check_rsp(tag);
    @(negedge CLK);
    check({tag, " pulse_end"}, 32'(RSP_VALID), 32'd0);
  endtask

  initial begin
    int busy;
    int rsp_at;
    int waited;

    // Reset held with a request pending: nothing may be accepted.
    RST_N = 1'b0; REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_WIDE = 1'b1;
    REQ_ADDR = 10'h000; REQ_WDATA = 16'h0000;
    repeat (3) @(negedge CLK);
    check("rst ready", 32'(REQ_READY), 32'd1);
    check("rst rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst we", 32'(RAM_WE), 32'd0);
    check("rst re", 32'(RAM_RE), 32'd0);
    check("rst rdata", 32'(RSP_RDATA), 32'd0);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst idle re", 32'(RAM_RE), 32'd0);

    // Narrow write then read back.
    do_req(1'b1, 1'b0, 10'h012, 16'h00A5, 16'h0000, 2, "nwr 012");
    check("mem 012", 32'(mem[10'h012]), 32'hA5);
    do_req(1'b0, 1'b0, 10'h012, 16'hFFFF, 16'h00A5, 2, "nrd 012");

    // Wide access across the address wrap.
    do_req(1'b1, 1'b1, 10'h3FF, 16'hBEEF, 16'h0000, 3, "wwr 3FF");
    check("mem 3FF", 32'(mem[10'h3FF]), 32'hEF);
    check("mem 000", 32'(mem[10'h000]), 32'hBE);
    do_req(1'b0, 1'b1, 10'h3FF, 16'h0000, 16'hBEEF, 3, "wrd 3FF");

    // Back-to-back: REQ_VALID held through a wide read.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_WIDE = 1'b1; REQ_ADDR = 10'h3FF;
    check("b2b ready0", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    sb.push_back(16'hBEEF);
    @(negedge CLK);
    REQ_WIDE = 1'b0; REQ_ADDR = 10'h012;
    busy = 0; rsp_at = 0;
    for (int i = 0; i < 10; i++) begin
      if (REQ_READY) break;
      busy++;
      if (RSP_VALID) begin
        rsp_at = busy;
        check_rsp("b2b first");
      end
      @(negedge CLK);
    end
    check("b2b busy_cycles", 32'(busy), 32'd3);
    check("b2b rsp_at", 32'(rsp_at), 32'd3);
    @(posedge CLK);
    sb.push_back(16'h00A5);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("b2b second re", 32'(RAM_RE), 32'd1);
    check("b2b second ra", 32'(RAM_RA), 32'h012);
    waited = 0;
    while (!RSP_VALID && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    check("b2b second rsp_seen", 32'(RSP_VALID), 32'd1);
    if (RSP_VALID) check_rsp("b2b second");
    @(negedge CLK);

    // Reset during BYTE1 of a wide write: first byte stays, second is dropped.
    do_req(1'b1, 1'b0, 10'h101, 16'h0077, 16'h0000, 2, "nwr 101");
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_WIDE = 1'b1; REQ_ADDR = 10'h100; REQ_WDATA = 16'h1234;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("abort byte0 we", 32'(RAM_WE), 32'd1);
    @(negedge CLK);
    check("abort byte1 wa", 32'(RAM_WA), 32'h101);
    RST_N = 1'b0;
    #1;
    check("abort we_dropped", 32'(RAM_WE), 32'd0);
    rsp_at = 0;
    repeat (2) begin
      @(negedge CLK);
      if (RSP_VALID) rsp_at++;
    end
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (RSP_VALID) rsp_at++;
    end
    check("abort no_rsp", 32'(rsp_at), 32'd0);
    check("abort mem 100", 32'(mem[10'h100]), 32'h34);
    check("abort mem 101", 32'(mem[10'h101]), 32'h77);

    // Unwritten wide read, then narrow read of a wide write's low byte.
    do_req(1'b0, 1'b1, 10'h200, 16'h0000, 16'h0000, 3, "wrd 200");
    do_req(1'b1, 1'b1, 10'h300, 16'hCAFE, 16'h0000, 3, "wwr 300");
    do_req(1'b0, 1'b0, 10'h300, 16'h0000, 16'h00FE, 2, "nrd 300");
    do_req(1'b0, 1'b1, 10'h300, 16'h0000, 16'hCAFE, 3, "wrd 300");

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
